// File: rtl/xibus_xcvr_seq.sv
// Local-bus transceiver sequencer: arbitrates slave register/ROM accesses and card-initiated master cycles.
// Latency: every output is registered; an input sampled at one edge shows its effect after the next edge.
// Backpressure: MACK paces the master data phase (bounded by TMO); MREQ while a master cycle is pending/busy is dropped.
module xibus_xcvr_seq #(
    parameter int NREG  = 4,
    parameter int NLANE = 4,
    parameter int TURN  = 1,
    parameter int TMO   = 255
) (
    input  logic                    clk,
    input  logic                    resetl,
    input  logic                    slave,
    input  logic                    tm1l,
    input  logic                    romsel,
    input  logic [$clog2(NREG)-1:0] rega,
    input  logic [NLANE-1:0]        lanen,
    input  logic                    mreq,
    input  logic                    mwrite,
    input  logic                    mack,
    output logic                    gba,
    output logic [NLANE-1:0]        gab,
    output logic [NREG-1:0]         rclk,
    output logic [NREG-1:0]         roe,
    output logic                    adrcy,
    output logic                    dtacy,
    output logic                    mbusy,
    output logic                    mdone,
    output logic                    mtmo
);

    localparam int RW = $clog2(NREG);
    localparam int MW = $clog2(TMO + 1);
    localparam logic [MW-1:0] MCNT_LAST = MW'(TMO - 1);
    localparam logic [2:0]    TCNT_LAST = 3'(TURN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S_RD,
        ST_S_WR,
        ST_M_ADDR,
        ST_M_DATA,
        ST_TURN
    } state_t;

    state_t           state_q, state_d;
    logic [NLANE-1:0] lanen_q;
    logic [RW-1:0]    rega_q;
    logic             rom_q;
    logic             first_q;
    logic [MW-1:0]    mcnt_q;
    logic [2:0]       tcnt_q;
    logic             pend_q;
    logic             mbsy_q;
    logic             mwr_q;
    logic             ack_q;
    logic             ackrd_q;
    logic             tmo_q;

    logic enter_slave;
    logic start_m;
    logic take_mreq;
    logic m_done;

    assign enter_slave = (state_q == ST_IDLE) && slave;
    assign start_m     = (state_q == ST_IDLE) && !slave && pend_q;
    assign take_mreq   = mreq && !mbsy_q;
    // Data phase ends on acknowledge or on the last counted cycle; MACK wins a tie.
    assign m_done      = (state_q == ST_M_DATA) && (mack || (mcnt_q == MCNT_LAST));

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (slave) begin
                    state_d = tm1l ? ST_S_WR : ST_S_RD;
                end else if (pend_q) begin
                    state_d = ST_M_ADDR;
                end
            end
            ST_S_RD, ST_S_WR: begin
                if (!slave) begin
                    if (TURN == 0) state_d = ST_IDLE;
                    else           state_d = ST_TURN;
                end
            end
            ST_M_ADDR: state_d = ST_M_DATA;
            ST_M_DATA: begin
                if (m_done) begin
                    if (TURN == 0) state_d = ST_IDLE;
                    else           state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                if (tcnt_q == TCNT_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            lanen_q <= '0;
            rega_q  <= '0;
            rom_q   <= 1'b0;
            first_q <= 1'b0;
            mcnt_q  <= '0;
            tcnt_q  <= '0;
            pend_q  <= 1'b0;
            mbsy_q  <= 1'b0;
            mwr_q   <= 1'b0;
            ack_q   <= 1'b0;
            ackrd_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            lanen_q <= lanen;
            first_q <= enter_slave;
            if (enter_slave) begin
                rega_q <= rega;
                rom_q  <= romsel;
            end
            ack_q   <= m_done && mack;
            ackrd_q <= m_done && mack && !mwr_q;
            tmo_q   <= m_done && !mack;
            if (state_q == ST_M_ADDR) begin
                mcnt_q <= '0;
            end else if ((state_q == ST_M_DATA) && (mcnt_q != '1)) begin
                mcnt_q <= mcnt_q + 1'b1;
            end
            if (state_q == ST_TURN) begin
                tcnt_q <= tcnt_q + 1'b1;
            end else begin
                tcnt_q <= '0;
            end
            // mbsy_q covers both pending and in-flight, so a request is only accepted when fully idle.
            if (take_mreq) begin
                pend_q <= 1'b1;
                mbsy_q <= 1'b1;
                mwr_q  <= mwrite;
            end else begin
                if (start_m) pend_q <= 1'b0;
                if (m_done)  mbsy_q <= 1'b0;
            end
        end
    end

    logic             gba_d;
    logic [NLANE-1:0] gab_d;
    logic [NREG-1:0]  rclk_d;
    logic [NREG-1:0]  roe_d;
    logic             adrcy_d;
    logic             dtacy_d;

    always_comb begin
        gba_d   = 1'b0;
        gab_d   = '0;
        rclk_d  = '0;
        roe_d   = '0;
        adrcy_d = 1'b0;
        dtacy_d = 1'b0;
        case (state_q)
            ST_S_WR: begin
                gba_d = 1'b1;
                if (first_q && !rom_q) rclk_d[rega_q] = 1'b1;
            end
            ST_S_RD: begin
                // The ROM only drives the top byte lane.
                if (rom_q) begin
                    gab_d[NLANE-1] = lanen_q[NLANE-1];
                end else begin
                    gab_d         = lanen_q;
                    roe_d[rega_q] = 1'b1;
                end
            end
            ST_M_ADDR: begin
                adrcy_d  = 1'b1;
                gab_d    = '1;
                roe_d[0] = 1'b1;
            end
            ST_M_DATA: begin
                dtacy_d = 1'b1;
                if (mwr_q) begin
                    roe_d[1] = 1'b1;
                    gab_d    = lanen_q;
                end else begin
                    gba_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (ackrd_q) rclk_d[1] = 1'b1;
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            gba   <= 1'b0;
            gab   <= '0;
            rclk  <= '0;
            roe   <= '0;
            adrcy <= 1'b0;
            dtacy <= 1'b0;
            mbusy <= 1'b0;
            mdone <= 1'b0;
            mtmo  <= 1'b0;
        end else begin
            gba   <= gba_d;
            gab   <= gab_d;
            rclk  <= rclk_d;
            roe   <= roe_d;
            adrcy <= adrcy_d;
            dtacy <= dtacy_d;
            mbusy <= mbsy_q | ack_q | tmo_q;
            mdone <= ack_q;
            mtmo  <= tmo_q;
        end
    end

endmodule

// File: doc/xibus_xcvr_seq.md
Name: xibus_xcvr_seq

Overview:
Parametrised, fully synchronous successor to the misc-PAL transceiver control on the local bus side of the test card. It arbitrates slave register accesses and card-initiated master cycles, sequences address and data phases itself, and drives registered, glitch-free enables to the bus transceivers and on-card registers. It generalises to NREG registers and NLANE byte lanes, and adds master handshake, timeout and turnaround.

Parameters:
NREG, 4, number of on-card registers (power of 2, 2..16); reg 0 = address reg, reg 1 = data reg
NLANE, 4, transceiver byte-lane groups
TURN, 1, idle cycles between transactions (0..7)
TMO, 255, master data-phase timeout in CLK cycles (1..65535)

Ports:
CLK  in  1  clock
RESETL  in  1  asynchronous active-low reset
SLAVE  in  1  card selected as slave (level)
TM1L  in  1  slave transfer mode: 1 = write, 0 = read
ROMSEL  in  1  slave access targets ROM, not registers
REGA  in  $clog2(NREG)  slave register index
LANEN  in  NLANE  byte lanes active for the access
MREQ  in  1  master request, one-cycle pulse
MWRITE  in  1  master direction, sampled with MREQ
MACK  in  1  bus acknowledge for the master data phase
GBA  out  1  bus-to-card transceiver enable
GAB  out  NLANE  card-to-bus per-lane enable
RCLK  out  NREG  register clock-enable, one-cycle pulse
ROE  out  NREG  register output enable
ADRCY  out  1  master address phase
DTACY  out  1  master data phase
MBUSY  out  1  master cycle pending or in progress
MDONE  out  1  one-cycle pulse, master cycle acknowledged
MTMO  out  1  one-cycle pulse, master cycle timed out

Behaviour:
- Reset: state IDLE; all outputs 0; pending-request flag, latched MWRITE, counters cleared. Reset can occur mid-cycle and aborts the cycle with no MDONE or MTMO.
- All outputs are registered (Moore). An input sampled at edge n produces its output effect after edge n+1.
- States: IDLE, S_RD, S_WR, M_ADDR, M_DATA, TURN.
- IDLE with SLAVE=1: go to S_RD if TM1L=0, or to S_WR if TM1L=1. Slave has priority over master.
- MREQ sets a pending flag and latches MWRITE, in any state. MBUSY=1 from the cycle after MREQ until the cycle after MDONE or MTMO. A MREQ while pending or busy is ignored.
- IDLE with SLAVE=0 and the pending flag set: go to M_ADDR and clear the flag.
- S_WR: GBA=1 throughout. RCLK[REGA] pulses for exactly the first cycle if ROMSEL=0; no RCLK if ROMSEL=1. Stay while SLAVE=1, then go to TURN.
- S_RD: GAB=LANEN. If ROMSEL=0, ROE[REGA]=1. If ROMSEL=1, no ROE and only GAB[NLANE-1] follows LANEN, because the ROM drives the top lane only. Stay while SLAVE=1, then go to TURN.
- REGA and TM1L are captured on S_RD/S_WR entry. Changes during the access are ignored.
- M_ADDR, exactly 1 cycle: ADRCY=1, GAB=all ones, ROE[0]=1. Then go to M_DATA.
- M_DATA: DTACY=1. The timeout counter starts at 0 on entry.
  - Write: ROE[1]=1, GAB=LANEN.
  - Read: GBA=1. The MACK cycle also pulses RCLK[1].
  - MACK=1: MDONE pulses, go to TURN.
  - Counter reaches TMO-1 without MACK: MTMO pulses, go to TURN, no RCLK.
  - MACK on the final timeout cycle counts as MDONE, not MTMO.
- TURN: all enables 0 for TURN cycles, then IDLE. With TURN=0 the FSM passes straight to IDLE in one cycle.
- Invariants: GBA and any GAB bit never both 1; ROE is at most one-hot; RCLK is at most one-hot.
- Counter width is $clog2(TMO+1). It saturates and never wraps.

Test Plan:
- Slave write: SLAVE=1, TM1L=1, REGA=2, ROMSEL=0 held 4 cycles -> RCLK=4'b0100 for exactly 1 cycle, GBA=1 for 4 cycles, then TURN for 1 cycle with all outputs 0.
- Slave read, ROM vs register: TM1L=0, LANEN=4'hF, ROMSEL=1 -> GAB=4'b1000, ROE=0. Repeat with ROMSEL=0, REGA=3 -> GAB=4'hF, ROE=4'b1000.
- Master write: MREQ with MWRITE=1, LANEN=4'b0011, MACK on 3rd data cycle -> ADRCY for 1 cycle with GAB=4'hF and ROE[0]; DTACY for 3 cycles with ROE[1] and GAB=4'b0011; MDONE for 1 cycle; MBUSY falls the next cycle.
- Master read timeout: TMO=4, MWRITE=0, no MACK -> DTACY and GBA for 4 cycles, MTMO pulse, no RCLK. Variant with MACK on cycle 4 -> MDONE and RCLK[1], no MTMO.
- Collision: MREQ and SLAVE rise in the same cycle -> slave access completes first, then TURN, then M_ADDR. A second MREQ while MBUSY=1 is ignored, giving only one master cycle.
- Reset mid M_DATA: RESETL low -> all outputs 0 immediately with no MDONE or MTMO. After release, IDLE with MBUSY=0.
